// File: rtl/ycbcr_to_rgb_pipe.sv
// Studio-range YCbCr to full-range RGB converter: three-stage pipeline with BT.601/BT.709 matrix select.
// Optional clamp counter on sat_cnt_o is built only when YCBCR_TO_RGB_SAT_CNT_EN is defined.
module ycbcr_to_rgb_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] y_data_i,
    input  logic [DATA_W-1:0] cb_data_i,
    input  logic [DATA_W-1:0] cr_data_i,
    input  logic              mode_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic [DATA_W-1:0] g_data_o,
    output logic [DATA_W-1:0] b_data_o,
    output logic [15:0]       sat_cnt_o
);

    localparam int YW = DATA_W + 1;   // signed offset-removed sample
    localparam int CW = FRAC_W + 3;   // unsigned 2.FRAC_W coefficient plus sign bit
    localparam int PW = YW + CW;      // full product width
    localparam int SW = PW + 2;       // sum of three products plus rounding constant

    // Coefficients are tabulated at 10 fraction bits and rescaled for other FRAC_W.
    function automatic logic signed [CW-1:0] coef(input int c10);
        int v;
        if (FRAC_W >= 10) begin
            v = c10 <<< (FRAC_W - 10);
        end else begin
            v = (c10 + (1 <<< (9 - FRAC_W))) >>> (10 - FRAC_W);
        end
        return CW'(v);
    endfunction

    localparam logic signed [CW-1:0] KY     = coef(1192);
    localparam logic signed [CW-1:0] KR_601 = coef(1634);
    localparam logic signed [CW-1:0] KGB_601 = coef(401);
    localparam logic signed [CW-1:0] KGR_601 = coef(833);
    localparam logic signed [CW-1:0] KB_601 = coef(2065);
    localparam logic signed [CW-1:0] KR_709 = coef(1836);
    localparam logic signed [CW-1:0] KGB_709 = coef(218);
    localparam logic signed [CW-1:0] KGR_709 = coef(546);
    localparam logic signed [CW-1:0] KB_709 = coef(2163);

    localparam logic signed [YW-1:0] OFF_Y = YW'(16 << (DATA_W - 8));
    localparam logic signed [YW-1:0] OFF_C = YW'(128 << (DATA_W - 8));
    localparam logic signed [SW-1:0] RND   = SW'(2 ** (FRAC_W - 1));
    localparam logic signed [SW-1:0] MAXV  = SW'((2 ** DATA_W) - 1);

    function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] v);
        if (v[SW-1]) begin
            return '0;
        end else if (v > MAXV) begin
            return '1;
        end
        return v[DATA_W-1:0];
    endfunction

    logic adv;

    // Stage 1: offset removal and mode capture
    logic                 v1_d, v1_q;
    logic                 mode1_d, mode1_q;
    logic signed [YW-1:0] y1_d, y1_q;
    logic signed [YW-1:0] cb1_d, cb1_q;
    logic signed [YW-1:0] cr1_d, cr1_q;

    // Stage 2: products
    logic                 v2_d, v2_q;
    logic signed [PW-1:0] p_yy_d, p_yy_q;
    logic signed [PW-1:0] p_rcr_d, p_rcr_q;
    logic signed [PW-1:0] p_gcb_d, p_gcb_q;
    logic signed [PW-1:0] p_gcr_d, p_gcr_q;
    logic signed [PW-1:0] p_bcb_d, p_bcb_q;
    logic signed [CW-1:0] kr_sel, kgb_sel, kgr_sel, kb_sel;

    // Stage 3: sum, round, clamp
    logic                 vo_d, vo_q;
    logic [DATA_W-1:0]    r_d, r_q;
    logic [DATA_W-1:0]    g_d, g_q;
    logic [DATA_W-1:0]    b_d, b_q;
    logic signed [SW-1:0] r_sum, g_sum, b_sum;
    logic signed [SW-1:0] r_sh, g_sh, b_sh;

    // Whole pipeline moves in lockstep; it only stalls when the output slot is full and blocked.
    assign adv     = ~vo_q | ready_i;
    assign ready_o = adv;

    always_comb begin
        v1_d    = v1_q;
        mode1_d = mode1_q;
        y1_d    = y1_q;
        cb1_d   = cb1_q;
        cr1_d   = cr1_q;
        if (adv) begin
            v1_d    = valid_i;
            mode1_d = mode_i;
            y1_d    = $signed({1'b0, y_data_i}) - OFF_Y;
            cb1_d   = $signed({1'b0, cb_data_i}) - OFF_C;
            cr1_d   = $signed({1'b0, cr_data_i}) - OFF_C;
        end
    end

    always_comb begin
        kr_sel  = mode1_q ? KR_709  : KR_601;
        kgb_sel = mode1_q ? KGB_709 : KGB_601;
        kgr_sel = mode1_q ? KGR_709 : KGR_601;
        kb_sel  = mode1_q ? KB_709  : KB_601;
    end

    always_comb begin
        v2_d    = v2_q;
        p_yy_d  = p_yy_q;
        p_rcr_d = p_rcr_q;
        p_gcb_d = p_gcb_q;
        p_gcr_d = p_gcr_q;
        p_bcb_d = p_bcb_q;
        if (adv) begin
            v2_d    = v1_q;
            p_yy_d  = PW'(y1_q)  * PW'(KY);
            p_rcr_d = PW'(cr1_q) * PW'(kr_sel);
            p_gcb_d = PW'(cb1_q) * PW'(kgb_sel);
            p_gcr_d = PW'(cr1_q) * PW'(kgr_sel);
            p_bcb_d = PW'(cb1_q) * PW'(kb_sel);
        end
    end

    always_comb begin
        r_sum = SW'(p_yy_q) + SW'(p_rcr_q) + RND;
        g_sum = SW'(p_yy_q) - SW'(p_gcb_q) - SW'(p_gcr_q) + RND;
        b_sum = SW'(p_yy_q) + SW'(p_bcb_q) + RND;
        r_sh  = r_sum >>> FRAC_W;
        g_sh  = g_sum >>> FRAC_W;
        b_sh  = b_sum >>> FRAC_W;
    end

    always_comb begin
        vo_d = vo_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        if (adv) begin
            vo_d = v2_q;
            r_d  = clamp(r_sh);
            g_d  = clamp(g_sh);
            b_d  = clamp(b_sh);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            mode1_q <= 1'b0;
            y1_q    <= '0;
            cb1_q   <= '0;
            cr1_q   <= '0;
            v2_q    <= 1'b0;
            p_yy_q  <= '0;
            p_rcr_q <= '0;
            p_gcb_q <= '0;
            p_gcr_q <= '0;
            p_bcb_q <= '0;
            vo_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            v1_q    <= v1_d;
            mode1_q <= mode1_d;
            y1_q    <= y1_d;
            cb1_q   <= cb1_d;
            cr1_q   <= cr1_d;
            v2_q    <= v2_d;
            p_yy_q  <= p_yy_d;
            p_rcr_q <= p_rcr_d;
            p_gcb_q <= p_gcb_d;
            p_gcr_q <= p_gcr_d;
            p_bcb_q <= p_bcb_d;
            vo_q    <= vo_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign valid_o  = vo_q;
    assign r_data_o = r_q;
    assign g_data_o = g_q;
    assign b_data_o = b_q;

`ifdef YCBCR_TO_RGB_SAT_CNT_EN
    function automatic logic clipped(input logic signed [SW-1:0] v);
        return v[SW-1] | (v > MAXV);
    endfunction

    logic        sat_d, sat_q;
    logic [15:0] sat_cnt_d, sat_cnt_q;

    // The clamp flag rides with the output pixel; counting happens on transfer, saturating at all-ones.
    always_comb begin
        sat_d     = sat_q;
        sat_cnt_d = sat_cnt_q;
        if (adv) begin
            sat_d = clipped(r_sh) | clipped(g_sh) | clipped(b_sh);
        end
        if (vo_q && ready_i && sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`else
    assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb_pipe.sv
// Self-checking bench for ycbcr_to_rgb_pipe: directed corner pixels, stall, mode alternation,
// mid-stream reset and a randomized handshake run scored against an integer reference model.
module tb_ycbcr_to_rgb_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] y_data_i = 8'd0;
    logic [7:0] cb_data_i = 8'd0;
    logic [7:0] cr_data_i = 8'd0;
    logic       mode_i = 1'b0;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic [7:0] r_data_o, g_data_o, b_data_o;
    logic [15:0] sat_cnt_o;

    always #5 clk = ~clk;

    ycbcr_to_rgb_pipe #(.DATA_W(8), .FRAC_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .y_data_i  (y_data_i),
        .cb_data_i (cb_data_i),
        .cr_data_i (cr_data_i),
        .mode_i    (mode_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .r_data_o  (r_data_o),
        .g_data_o  (g_data_o),
        .b_data_o  (b_data_o),
        .sat_cnt_o (sat_cnt_o)
    );

    typedef struct {
        int r;
        int g;
        int b;
        bit sat;
        int acc;
    } px_t;

    px_t exp_q[$];
    int  n_vec   = 0;
    int  n_err   = 0;
    int  cyc     = 0;
    int  n_px    = 0;
    int  exp_sat = 0;
    bit  lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int clip8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Conversion straight from the matrix definition at 10 fraction bits.
    function automatic px_t ref_px(input int y, input int cb, input int cr, input bit md, input int acc);
        px_t p;
        int yp  = y - 16;
        int cbp = cb - 128;
        int crp = cr - 128;
        int kr  = md ? 1836 : 1634;
        int kgb = md ? 218  : 401;
        int kgr = md ? 546  : 833;
        int kb  = md ? 2163 : 2065;
        int rv  = (1192 * yp + kr * crp + 512) >>> 10;
        int gv  = (1192 * yp - kgb * cbp - kgr * crp + 512) >>> 10;
        int bv  = (1192 * yp + kb * cbp + 512) >>> 10;
        p.r   = clip8(rv);
        p.g   = clip8(gv);
        p.b   = clip8(bv);
        p.sat = (p.r != rv) || (p.g != gv) || (p.b != bv);
        p.acc = acc;
        return p;
    endfunction

    // One cycle: observe handshakes mid-cycle (inputs already driven), then move to the next negedge.
    task automatic tick();
        px_t e;
        #1;
        if (ready_i) chk("ready_o_free", {31'd0, ready_o}, 32'd1);
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'd0, valid_o}, 32'd0);
            end else begin
                e = exp_q[0];
                chk("r_data", {24'd0, r_data_o}, e.r);
                chk("g_data", {24'd0, g_data_o}, e.g);
                chk("b_data", {24'd0, b_data_o}, e.b);
                if (!ready_i) begin
                    chk("ready_o_stall", {31'd0, ready_o}, 32'd0);
                end else begin
                    chk("sat_cnt", {16'd0, sat_cnt_o}, exp_sat);
                    if (lat_chk) chk("latency", cyc - e.acc, 32'd3);
                    $display("px %0d: rgb %0d/%0d/%0d sat=%0b cnt=%0d", n_px, r_data_o, g_data_o, b_data_o,
                             e.sat, sat_cnt_o);
                    n_px++;
`ifdef YCBCR_TO_RGB_SAT_CNT_EN
                    if (e.sat && exp_sat < 16'hFFFF) exp_sat++;
`endif
                    void'(exp_q.pop_front());
                end
            end
        end
        if (valid_i && ready_o) exp_q.push_back(ref_px(y_data_i, cb_data_i, cr_data_i, mode_i, cyc));
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input int y, input int cb, input int cr, input bit md);
        valid_i   = 1'b1;
        y_data_i  = 8'(y);
        cb_data_i = 8'(cb);
        cr_data_i = 8'(cr);
        mode_i    = md;
        tick();
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state is visible while rst is still high, before any clock edge.
        #1;
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
        chk("rst_sat_cnt", {16'd0, sat_cnt_o}, 32'd0);
        chk("rst_r_data", {24'd0, r_data_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Black, white in both modes, red corner with clamping; exact 3-cycle latency.
        lat_chk = 1'b1;
        ready_i = 1'b1;
        send(16, 128, 128, 1'b0);
        idle(4);
        send(235, 128, 128, 1'b0);
        send(235, 128, 128, 1'b1);
        send(81, 90, 240, 1'b0);
        idle(5);
        chk("sat_after_red", {16'd0, sat_cnt_o}, exp_sat);

        // Mode alternates on identical input.
        for (int i = 0; i < 6; i++) send(81, 90, 240, i[0]);
        idle(5);

        // Three pixels in flight, then downstream blocks for five cycles.
        lat_chk = 1'b0;
        send(100, 60, 200, 1'b0);
        send(180, 200, 50, 1'b1);
        send(50, 140, 120, 1'b0);
        valid_i = 1'b0;
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        drain();

        // Randomized valid/ready traffic with random pixels and modes.
        for (int i = 0; i < 400; i++) begin
            valid_i   = ($urandom_range(0, 3) != 0);
            ready_i   = ($urandom_range(0, 9) < 7);
            y_data_i  = 8'($urandom_range(0, 255));
            cb_data_i = 8'($urandom_range(0, 255));
            cr_data_i = 8'($urandom_range(0, 255));
            mode_i    = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        chk("sat_cnt_final", {16'd0, sat_cnt_o}, exp_sat);

        // Reset with all three stages holding saturating pixels.
        ready_i = 1'b1;
        send(81, 90, 240, 1'b0);
        send(81, 90, 240, 1'b1);
        send(0, 0, 255, 1'b0);
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("midrst_sat_cnt", {16'd0, sat_cnt_o}, 32'd0);
        chk("midrst_r_data", {24'd0, r_data_o}, 32'd0);
        chk("midrst_ready_o", {31'd0, ready_o}, 32'd1);
        exp_q.delete();
        exp_sat = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        lat_chk = 1'b1;
        send(235, 128, 128, 1'b1);
        idle(5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
